core_ex_lsu: RTL and testbench

//  Load/store unit of the EX stage. Accepts one memory op per request from EX and runs it on a

---
 rtl/core_ex_lsu_pkg.sv | 34 +++
 rtl/core_lsu_align.sv | 99 +++++++++
 rtl/core_ex_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_core_ex_lsu.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ex_lsu_pkg.sv
// -----------------------------------------------------------------------------
// core_ex_lsu_pkg
//   Shared encodings for the EX-stage load/store unit.
//   - CORE_XLEN        : data/address width (only 32 is supported)
//   - LSU_SIZE_*       : access size encodings on lsu_size (3 is illegal)
//   - lsu_state_e      : LSU control FSM states (2-bit)
//   - lsu_op_t         : op fields latched when a request is accepted
// -----------------------------------------------------------------------------
package core_ex_lsu_pkg;

   localparam int CORE_XLEN = 32;

   localparam logic [1:0] LSU_SIZE_B = 2'd0;
   localparam logic [1:0] LSU_SIZE_H = 2'd1;
   localparam logic [1:0] LSU_SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      LSU_ST_IDLE = 2'd0,
      LSU_ST_REQ  = 2'd1,
      LSU_ST_WAIT = 2'd2,
      LSU_ST_DONE = 2'd3
   } lsu_state_e;

   // Only the low address bits are kept: the aligned word address lives in
   // the bus address register, the offset is needed later for lane select.
   typedef struct packed {
      logic       store;
      logic [1:0] size;
      logic       zext;
      logic [1:0] offset;
      logic       misalign;
   } lsu_op_t;

endpackage

// File: rtl/core_lsu_align.sv
// -----------------------------------------------------------------------------
// core_lsu_align
//   Purely combinational data alignment for the load/store unit.
//   Store side (driven from the incoming request):
//     req_store_i, req_size_i, req_off_i, req_wdata_i
//       -> req_wstrb_o    byte strobes (0 for loads)
//       -> req_wdata_o    store data replicated across lanes (0 for loads)
//       -> req_misalign_o size/offset fault (also flags illegal size 3)
//   Load side (driven from the latched op and the raw bus word):
//     ld_size_i, ld_zext_i, ld_off_i, ld_rdata_i
//       -> ld_result_o    lane-extracted, sign- or zero-extended load data
//   The lane logic assumes XLEN = 32 (four byte lanes, 2-bit offset).
// -----------------------------------------------------------------------------
module core_lsu_align
   import core_ex_lsu_pkg::*;
#(
   parameter int XLEN = CORE_XLEN
) (
   input  logic              req_store_i,
   input  logic [1:0]        req_size_i,
   input  logic [1:0]        req_off_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   output logic [XLEN/8-1:0] req_wstrb_o,
   output logic [XLEN-1:0]   req_wdata_o,
   output logic              req_misalign_o,
   input  logic [1:0]        ld_size_i,
   input  logic              ld_zext_i,
   input  logic [1:0]        ld_off_i,
   input  logic [XLEN-1:0]   ld_rdata_i,
   output logic [XLEN-1:0]   ld_result_o
);

   localparam int LANES = XLEN / 8;

   // ---------------------------------------------------------------------
   // Store data: each lane carries the byte of wdata that would land there
   // if the access were placed at any legal offset, so the strobes alone
   // pick the bytes that are actually written.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [7:0] lane_byte;

         always_comb begin
            case (req_size_i)
               LSU_SIZE_B: lane_byte = req_wdata_i[7:0];
               LSU_SIZE_H: lane_byte = req_wdata_i[(gi % 2) * 8 +: 8];
               default:    lane_byte = req_wdata_i[gi * 8 +: 8];
            endcase
         end

         assign req_wdata_o[gi * 8 +: 8] = req_store_i ? lane_byte : 8'h00;
      end
   endgenerate

   always_comb begin
      req_wstrb_o = '0;
      if (req_store_i) begin
         case (req_size_i)
            LSU_SIZE_B: req_wstrb_o = LANES'(1) << req_off_i;
            LSU_SIZE_H: req_wstrb_o = LANES'(3) << {req_off_i[1], 1'b0};
            LSU_SIZE_W: req_wstrb_o = '1;
            default:    req_wstrb_o = '0;
         endcase
      end
   end

   always_comb begin
      case (req_size_i)
         LSU_SIZE_B: req_misalign_o = 1'b0;
         LSU_SIZE_H: req_misalign_o = req_off_i[0];
         LSU_SIZE_W: req_misalign_o = (req_off_i != 2'b00);
         default:    req_misalign_o = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------
   // Load formatting
   // ---------------------------------------------------------------------
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        ld_byte_sign;
   logic        ld_half_sign;

   assign ld_byte      = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
   assign ld_half      = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];
   assign ld_byte_sign = ~ld_zext_i & ld_byte[7];
   assign ld_half_sign = ~ld_zext_i & ld_half[15];

   always_comb begin
      case (ld_size_i)
         LSU_SIZE_B: ld_result_o = {{(XLEN - 8){ld_byte_sign}}, ld_byte};
         LSU_SIZE_H: ld_result_o = {{(XLEN - 16){ld_half_sign}}, ld_half};
         default:    ld_result_o = ld_rdata_i;
      endcase
   end

endmodule

// File: rtl/core_ex_lsu.sv
// -----------------------------------------------------------------------------
// core_ex_lsu
//   EX-stage load/store unit. Takes one memory op per lsu_req pulse, runs it
//   on a valid/ready data-memory bus and returns a formatted, registered
//   result with a one-cycle lsu_valid pulse to the writeback unit.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     flush                         kill the current op's writeback
//     lsu_req/store/size/unsigned   op request from EX (req honoured in IDLE)
//     lsu_addr, lsu_wdata           effective address, right-justified data
//     lsu_busy                      stall EX while an op is in flight
//     lsu_valid, lsu_result         completion pulse and registered result
//     lsu_misalign                  fault flag, meaningful with lsu_valid
//     mem_req_valid/ready/addr/wen/wstrb/wdata   bus request channel
//     mem_rsp_valid, mem_rsp_rdata  bus response (ack for stores)
// -----------------------------------------------------------------------------
module core_ex_lsu
   import core_ex_lsu_pkg::*;
#(
   parameter int XLEN = CORE_XLEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              lsu_req,
   input  logic              lsu_store,
   input  logic [1:0]        lsu_size,
   input  logic              lsu_unsigned,
   input  logic [XLEN-1:0]   lsu_addr,
   input  logic [XLEN-1:0]   lsu_wdata,
   output logic              lsu_busy,
   output logic              lsu_valid,
   output logic [XLEN-1:0]   lsu_result,
   output logic              lsu_misalign,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic              mem_req_wen,
   output logic [XLEN/8-1:0] mem_req_wstrb,
   output logic [XLEN-1:0]   mem_req_wdata,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata
);

   lsu_state_e        state_q, state_d;
   lsu_op_t           op_q, op_d;
   logic              killed_q, killed_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic              mem_wen_q, mem_wen_d;
   logic [XLEN/8-1:0] mem_wstrb_q, mem_wstrb_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

   logic              accept;
   logic [XLEN/8-1:0] align_wstrb;
   logic [XLEN-1:0]   align_wdata;
   logic              align_misalign;
   logic [XLEN-1:0]   align_ld_result;

   // A flush in IDLE wins over a same-cycle request.
   assign accept = (state_q == LSU_ST_IDLE) & lsu_req & ~flush;

   core_lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .req_store_i    (lsu_store),
      .req_size_i     (lsu_size),
      .req_off_i      (lsu_addr[1:0]),
      .req_wdata_i    (lsu_wdata),
      .req_wstrb_o    (align_wstrb),
      .req_wdata_o    (align_wdata),
      .req_misalign_o (align_misalign),
      .ld_size_i      (op_q.size),
      .ld_zext_i      (op_q.zext),
      .ld_off_i       (op_q.offset),
      .ld_rdata_i     (mem_rsp_rdata),
      .ld_result_o    (align_ld_result)
   );

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LSU_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_ST_IDLE: begin
            if (accept) begin
               // Faulting ops skip the bus entirely.
               state_d = align_misalign ? LSU_ST_DONE : LSU_ST_REQ;
            end
         end
         LSU_ST_REQ: begin
            if (mem_req_ready) begin
               state_d = LSU_ST_WAIT;
            end
         end
         LSU_ST_WAIT: begin
            if (mem_rsp_valid) begin
               state_d = LSU_ST_DONE;
            end
         end
         default: begin
            state_d = LSU_ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // The request and completion strobes are masked by rst so the bus never
   // sees a request that the reset is about to forget.
   // ---------------------------------------------------------------------
   always_comb begin
      lsu_busy      = 1'b0;
      lsu_valid     = 1'b0;
      mem_req_valid = 1'b0;
      case (state_q)
         LSU_ST_IDLE: begin
            lsu_busy = lsu_req;
         end
         LSU_ST_REQ: begin
            lsu_busy      = 1'b1;
            mem_req_valid = ~rst;
         end
         LSU_ST_WAIT: begin
            lsu_busy = 1'b1;
         end
         default: begin
            lsu_valid = ~killed_q & ~flush & ~rst;
         end
      endcase
   end

   assign lsu_misalign  = lsu_valid & op_q.misalign;
   assign lsu_result    = result_q;
   assign mem_req_addr  = mem_addr_q;
   assign mem_req_wen   = mem_wen_q;
   assign mem_req_wstrb = mem_wstrb_q;
   assign mem_req_wdata = mem_wdata_q;

   // ---------------------------------------------------------------------
   // Datapath next values
   // ---------------------------------------------------------------------
   always_comb begin
      op_d        = op_q;
      killed_d    = killed_q;
      result_d    = result_q;
      mem_addr_d  = mem_addr_q;
      mem_wen_d   = mem_wen_q;
      mem_wstrb_d = mem_wstrb_q;
      mem_wdata_d = mem_wdata_q;

      if (accept) begin
         op_d.store    = lsu_store;
         op_d.size     = lsu_size;
         op_d.zext     = lsu_unsigned;
         op_d.offset   = lsu_addr[1:0];
         op_d.misalign = align_misalign;
         if (align_misalign) begin
            // A fault completes with a zero result and no bus activity;
            // the bus registers keep their previous contents.
            result_d = '0;
         end else begin
            mem_addr_d  = {lsu_addr[XLEN-1:2], 2'b00};
            mem_wen_d   = lsu_store;
            mem_wstrb_d = align_wstrb;
            mem_wdata_d = align_wdata;
         end
      end

      // A flushed op still finishes its bus transaction, but its data is
      // not a completion, so the visible result keeps the last one.
      if ((state_q == LSU_ST_WAIT) && mem_rsp_valid && !killed_q && !flush) begin
         result_d = op_q.store ? '0 : align_ld_result;
      end

      if (((state_q == LSU_ST_REQ) || (state_q == LSU_ST_WAIT)) && flush) begin
         killed_d = 1'b1;
      end else if (state_q == LSU_ST_DONE) begin
         // DONE always returns to IDLE, which is where the kill is dropped.
         killed_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q        <= '0;
         killed_q    <= 1'b0;
         result_q    <= '0;
         mem_addr_q  <= '0;
         mem_wen_q   <= 1'b0;
         mem_wstrb_q <= '0;
         mem_wdata_q <= '0;
      end else begin
         op_q        <= op_d;
         killed_q    <= killed_d;
         result_q    <= result_d;
         mem_addr_q  <= mem_addr_d;
         mem_wen_q   <= mem_wen_d;
         mem_wstrb_q <= mem_wstrb_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_core_ex_lsu.sv
// -----------------------------------------------------------------------------
// tb_core_ex_lsu
//   Self-checking bench for core_ex_lsu: a table of directed ops, a batch of
//   random ops checked against a byte-arithmetic reference model, and
//   hand-written flush/reset sequences.
// -----------------------------------------------------------------------------
module tb_core_ex_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        lsu_req;
   logic        lsu_store;
   logic [1:0]  lsu_size;
   logic        lsu_unsigned;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_busy;
   logic        lsu_valid;
   logic [31:0] lsu_result;
   logic        lsu_misalign;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [3:0]  mem_req_wstrb;
   logic [31:0] mem_req_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;

   int total = 0;
   int bad   = 0;
   int op_no = 0;

   always #5 clk = ~clk;

   core_ex_lsu #(.XLEN(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .lsu_req       (lsu_req),
      .lsu_store     (lsu_store),
      .lsu_size      (lsu_size),
      .lsu_unsigned  (lsu_unsigned),
      .lsu_addr      (lsu_addr),
      .lsu_wdata     (lsu_wdata),
      .lsu_busy      (lsu_busy),
      .lsu_valid     (lsu_valid),
      .lsu_result    (lsu_result),
      .lsu_misalign  (lsu_misalign),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wen   (mem_req_wen),
      .mem_req_wstrb (mem_req_wstrb),
      .mem_req_wdata (mem_req_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata)
   );

   typedef struct packed {
      bit        store;
      bit [1:0]  size;
      bit        zext;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [31:0] rdata;
      int        rdly;      // extra cycles before mem_req_ready
      int        sdly;      // extra cycles before mem_rsp_valid
      bit        noise;     // spurious lsu_req / rsp pulses while busy
      bit        exp_mis;
      bit [31:0] exp_res;
      bit [3:0]  exp_strb;
      bit [31:0] exp_bw;
   } vec_t;

   // ---------------- reference model (byte arithmetic) ----------------
   function automatic bit m_mis(bit [1:0] size, bit [31:0] addr);
      if (size == 2'd3) return 1'b1;
      return (addr % (32'd1 << size)) != 0;
   endfunction

   function automatic bit [31:0] m_load(bit [1:0] size, bit zext, bit [31:0] addr, bit [31:0] rdata);
      int        nbytes = 1 << size;
      bit [31:0] mask;
      bit [31:0] v;
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      v = (rdata >> (8 * (addr % 4))) & mask;
      if (!zext && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit [3:0] m_strb(bit [1:0] size, bit [31:0] addr);
      int nbytes = 1 << size;
      bit [7:0] s;
      s = 8'(((1 << nbytes) - 1) << (addr % 4));
      return s[3:0];
   endfunction

   function automatic bit [31:0] m_bus_wdata(bit [1:0] size, bit [31:0] wdata);
      int nbytes = 1 << size;
      bit [31:0] r;
      for (int i = 0; i < 4; i++) r[8 * i +: 8] = wdata[8 * (i % nbytes) +: 8];
      return r;
   endfunction

   function automatic vec_t mk(bit store, bit [1:0] size, bit zext, bit [31:0] addr,
                               bit [31:0] wdata, bit [31:0] rdata, int rdly, int sdly, bit noise,
                               bit exp_mis, bit [31:0] exp_res, bit [3:0] exp_strb, bit [31:0] exp_bw);
      vec_t v;
      v.store = store; v.size = size; v.zext = zext; v.addr = addr;
      v.wdata = wdata; v.rdata = rdata; v.rdly = rdly; v.sdly = sdly; v.noise = noise;
      v.exp_mis = exp_mis; v.exp_res = exp_res; v.exp_strb = exp_strb; v.exp_bw = exp_bw;
      return v;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s (op %0d): got 0x%08h, expected 0x%08h", name, op_no, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush         = 1'b0;
      lsu_req       = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
   endtask

   // Drives one op end to end with a cooperative memory and checks every cycle.
   task automatic run_op(input vec_t v);
      bit [31:0] aligned;
      aligned = {v.addr[31:2], 2'b00};
      op_no++;
      // cycle 0: request
      idle_inputs();
      lsu_req = 1'b1; lsu_store = v.store; lsu_size = v.size;
      lsu_unsigned = v.zext; lsu_addr = v.addr; lsu_wdata = v.wdata;
      #1;
      check("busy_on_req", 32'(lsu_busy), 32'd1);
      check("no_valid_c0", 32'(lsu_valid), 32'd0);
      tick();
      lsu_req = 1'b0;
      if (v.exp_mis) begin
         #1;
         check("mis_valid", 32'(lsu_valid), 32'd1);
         check("mis_flag", 32'(lsu_misalign), 32'd1);
         check("mis_no_bus", 32'(mem_req_valid), 32'd0);
         check("mis_result", lsu_result, 32'd0);
         check("mis_busy", 32'(lsu_busy), 32'd0);
      end else begin
         for (int k = 0; k <= v.rdly; k++) begin
            mem_req_ready = (k == v.rdly);
            if (v.noise) begin
               lsu_req = 1'b1; lsu_addr = $urandom; lsu_store = 1'($urandom);
               lsu_wdata = $urandom; mem_rsp_valid = 1'($urandom);
            end
            #1;
            check("req_valid", 32'(mem_req_valid), 32'd1);
            check("req_addr", mem_req_addr, aligned);
            check("req_wen", 32'(mem_req_wen), 32'(v.store));
            check("req_wstrb", 32'(mem_req_wstrb), v.store ? 32'(v.exp_strb) : 32'd0);
            if (v.store) check("req_wdata", mem_req_wdata, v.exp_bw);
            check("req_busy", 32'(lsu_busy), 32'd1);
            check("req_no_valid", 32'(lsu_valid), 32'd0);
            tick();
         end
         mem_req_ready = 1'b0;
         for (int k = 0; k <= v.sdly; k++) begin
            mem_rsp_valid = (k == v.sdly);
            mem_rsp_rdata = (k == v.sdly) ? v.rdata : $urandom;
            lsu_req = v.noise;
            #1;
            check("wait_no_req", 32'(mem_req_valid), 32'd0);
            check("wait_busy", 32'(lsu_busy), 32'd1);
            check("wait_no_valid", 32'(lsu_valid), 32'd0);
            tick();
         end
         idle_inputs();
         #1;
         check("done_valid", 32'(lsu_valid), 32'd1);
         check("done_mis", 32'(lsu_misalign), 32'd0);
         check("done_result", lsu_result, v.exp_res);
         check("done_busy", 32'(lsu_busy), 32'd0);
      end
      $display("op %0d: %s size=%0d zext=%0d addr=0x%08h result=0x%08h misalign=%0d",
               op_no, v.store ? "ST" : "LD", v.size, v.zext, v.addr, lsu_result, lsu_misalign);
      tick();
      #1;
      check("idle_no_valid", 32'(lsu_valid), 32'd0);
      check("idle_hold_res", lsu_result, v.exp_res);
   endtask

   vec_t tbl[14];
   vec_t rv;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(0, 2'd2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 4'h0, 32'h0);
      tbl[1]  = mk(0, 2'd0, 0, 32'h103, 32'h0,        32'h80123456, 0, 0, 0, 0, 32'hFFFFFF80, 4'h0, 32'h0);
      tbl[2]  = mk(0, 2'd0, 1, 32'h103, 32'h0,        32'h80123456, 0, 0, 0, 0, 32'h00000080, 4'h0, 32'h0);
      tbl[3]  = mk(0, 2'd1, 0, 32'h102, 32'h0,        32'h80011234, 0, 0, 0, 0, 32'hFFFF8001, 4'h0, 32'h0);
      tbl[4]  = mk(1, 2'd0, 0, 32'h101, 32'h0000005A, 32'h0,        0, 0, 0, 0, 32'h0,        4'b0010, 32'h5A5A5A5A);
      tbl[5]  = mk(0, 2'd2, 0, 32'h102, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        4'h0, 32'h0);
      tbl[6]  = mk(0, 2'd2, 0, 32'h104, 32'h0,        32'h12345678, 5, 0, 1, 0, 32'h12345678, 4'h0, 32'h0);
      tbl[7]  = mk(1, 2'd1, 0, 32'h106, 32'hABCD1234, 32'h0,        1, 2, 0, 0, 32'h0,        4'b1100, 32'h12341234);
      tbl[8]  = mk(1, 2'd2, 0, 32'h108, 32'hCAFEF00D, 32'h0,        0, 1, 1, 0, 32'h0,        4'hF, 32'hCAFEF00D);
      tbl[9]  = mk(0, 2'd1, 1, 32'h10A, 32'h0,        32'hF00D0000, 0, 3, 0, 0, 32'h0000F00D, 4'h0, 32'h0);
      tbl[10] = mk(0, 2'd0, 0, 32'h100, 32'h0,        32'h0000007F, 2, 0, 0, 0, 32'h0000007F, 4'h0, 32'h0);
      tbl[11] = mk(0, 2'd3, 0, 32'h100, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0,        4'h0, 32'h0);
      tbl[12] = mk(1, 2'd1, 0, 32'h101, 32'h1234,     32'h0,        0, 0, 0, 1, 32'h0,        4'h0, 32'h0);
      tbl[13] = mk(0, 2'd1, 0, 32'h100, 32'h0,        32'h1234FFFE, 0, 0, 0, 0, 32'hFFFFFFFE, 4'h0, 32'h0);

      // ---------------- reset state ----------------
      rst = 1'b1;
      idle_inputs();
      lsu_store = 1'b0; lsu_size = 2'd0; lsu_unsigned = 1'b0;
      lsu_addr = 32'h0; lsu_wdata = 32'h0; mem_rsp_rdata = 32'h0;
      repeat (3) tick();
      #1;
      check("rst_busy", 32'(lsu_busy), 32'd0);
      check("rst_valid", 32'(lsu_valid), 32'd0);
      check("rst_result", lsu_result, 32'd0);
      check("rst_mis", 32'(lsu_misalign), 32'd0);
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_bus", {mem_req_addr[31:5], mem_req_wen, mem_req_wstrb}, 32'd0);
      check("rst_wdata", mem_req_wdata, 32'd0);
      rst = 1'b0;
      tick();

      // ---------------- directed table ----------------
      foreach (tbl[i]) run_op(tbl[i]);

      // ---------------- random ops vs model ----------------
      for (int n = 0; n < 60; n++) begin
         rv.store = 1'($urandom);
         rv.size  = 2'($urandom_range(0, 3));
         rv.zext  = 1'($urandom);
         rv.addr  = 32'h200 + 32'($urandom_range(0, 63));
         rv.wdata = $urandom;
         rv.rdata = $urandom;
         rv.rdly  = $urandom_range(0, 3);
         rv.sdly  = $urandom_range(0, 3);
         rv.noise = 1'($urandom);
         rv.exp_mis  = m_mis(rv.size, rv.addr);
         rv.exp_res  = (rv.store || rv.exp_mis) ? 32'h0 : m_load(rv.size, rv.zext, rv.addr, rv.rdata);
         rv.exp_strb = rv.exp_mis ? 4'h0 : m_strb(rv.size, rv.addr);
         rv.exp_bw   = rv.exp_mis ? 32'h0 : m_bus_wdata(rv.size, rv.wdata);
         run_op(rv);
      end

      // ---------------- flush in WAIT ----------------
      run_op(mk(0, 2'd2, 0, 32'h300, 32'h0, 32'hA5A5A5A5, 0, 0, 0, 0, 32'hA5A5A5A5, 4'h0, 32'h0));
      op_no++;
      idle_inputs();
      lsu_req = 1'b1; lsu_store = 1'b0; lsu_size = 2'd2; lsu_addr = 32'h310;
      tick();
      lsu_req = 1'b0; mem_req_ready = 1'b1;
      #1;
      check("fw_req_valid", 32'(mem_req_valid), 32'd1);
      tick();
      mem_req_ready = 1'b0; flush = 1'b1;
      #1;
      check("fw_busy", 32'(lsu_busy), 32'd1);
      tick();
      flush = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h11111111;
      #1;
      check("fw_no_req", 32'(mem_req_valid), 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      check("fw_killed_valid", 32'(lsu_valid), 32'd0);
      check("fw_busy_drop", 32'(lsu_busy), 32'd0);
      tick();
      #1;
      check("fw_idle_valid", 32'(lsu_valid), 32'd0);
      check("fw_result_hold", lsu_result, 32'hA5A5A5A5);
      $display("op %0d: flushed LD in WAIT, no completion", op_no);
      run_op(mk(0, 2'd2, 0, 32'h314, 32'h0, 32'h0BADF00D, 0, 0, 0, 0, 32'h0BADF00D, 4'h0, 32'h0));

      // ---------------- flush beats request in IDLE ----------------
      op_no++;
      idle_inputs();
      lsu_req = 1'b1; flush = 1'b1; lsu_store = 1'b0; lsu_size = 2'd2; lsu_addr = 32'h320;
      tick();
      idle_inputs();
      #1;
      check("fi_no_req", 32'(mem_req_valid), 32'd0);
      check("fi_no_valid", 32'(lsu_valid), 32'd0);
      check("fi_not_busy", 32'(lsu_busy), 32'd0);
      $display("op %0d: request dropped by same-cycle flush", op_no);
      tick();

      // ---------------- flush in DONE ----------------
      op_no++;
      lsu_req = 1'b1; lsu_size = 2'd2; lsu_addr = 32'h330;
      tick();
      lsu_req = 1'b0; mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h33333333;
      tick();
      mem_rsp_valid = 1'b0; flush = 1'b1;
      #1;
      check("fd_valid_suppr", 32'(lsu_valid), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      check("fd_idle_valid", 32'(lsu_valid), 32'd0);
      check("fd_idle_req", 32'(mem_req_valid), 32'd0);
      $display("op %0d: completion suppressed by flush in DONE", op_no);

      // ---------------- reset mid-transaction ----------------
      op_no++;
      lsu_req = 1'b1; lsu_store = 1'b1; lsu_size = 2'd2; lsu_addr = 32'h340; lsu_wdata = 32'h77777777;
      tick();
      lsu_req = 1'b0;
      #1;
      check("rm_req_up", 32'(mem_req_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("rm_req_killed", 32'(mem_req_valid), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("rm_busy", 32'(lsu_busy), 32'd0);
      check("rm_result", lsu_result, 32'd0);
      check("rm_bus_addr", mem_req_addr, 32'd0);
      check("rm_bus_wdata", mem_req_wdata, 32'd0);
      $display("op %0d: reset during REQ", op_no);
      tick();
      run_op(mk(1, 2'd0, 0, 32'h343, 32'h000000C3, 32'h0, 0, 0, 0, 0, 32'h0, 4'b1000, 32'hC3C3C3C3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
